io_ws: RTL and testbench

Parametrised successor to the CPU bus I/O decoder: decodes the 16-bit address into ROM / low-RAM / high-RAM chip selects, banked high-RAM windows and the 0xFFxx I/O page. It now holds the control register (CR) internally, with write and read-back, and inserts per-device wait states on `n_rdy` for slow peripherals (keyboard, LCD). Sits between the CPU bus and the memory/peripheral chips, replacing the purely combinational decoder.

---
 rtl/io_ws.sv | 155 +++++++++++++++
 tb/tb_io_ws.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_ws.sv
// io_ws -- CPU bus I/O decoder with internal control register and wait states.
//
// Decodes the 16-bit CPU address into ROM / low-RAM / high-RAM chip selects,
// N_WIN banked 4 KiB high-RAM windows from 0xA000, and the 0xFFxx I/O page
// (keyboard, LCD, control register, reserved). The control register (CR) is
// held here. A per-device wait-state counter stretches n_rdy for slow
// peripherals.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   a          CPU address
//   n_oe/n_we  read / write strobes, active low
//   d_in       CPU write data (CR writes)
//   d_out      CR read-back data (0 when not reading CR)
//   d_oe       high while d_out must drive the bus
//   cr         current CR value
//   n_rdy      high = not ready (unmapped address or wait state)
//   n_rom_cs, n_raml_cs, n_ramh_cs  memory chip selects, active low
//   n_kb_oe    keyboard read enable, active low
//   kb_cp      keyboard latch clock (rises at end of write)
//   lcd_e      LCD enable, active high
module io_ws #(
  parameter int unsigned N_WIN    = 5,
  parameter int unsigned KB_WS    = 0,
  parameter int unsigned LCD_WS   = 3,
  parameter logic [7:0]  CR_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] a,
  input  logic        n_oe,
  input  logic        n_we,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic [7:0]  cr,
  output logic        n_rdy,
  output logic        n_rom_cs,
  output logic        n_raml_cs,
  output logic        n_ramh_cs,
  output logic        n_kb_oe,
  output logic        kb_cp,
  output logic        lcd_e
);

  localparam logic [3:0] KB_W  = 4'(KB_WS);
  localparam logic [3:0] LCD_W = 4'(LCD_WS);

  logic        strb;
  logic        strb_q;
  logic [15:0] a_q;
  logic        start;
  logic [3:0]  cnt;
  logic [3:0]  dev_ws;
  logic        busy;
  logic        wr_done;
  logic        commit;

  logic        in_low;
  logic        in_mid;
  logic        in_io;
  logic        in_win;
  logic [2:0]  win_idx;
  logic [7:0]  win_en;
  logic        win_hit;
  logic        unmapped;

  logic        kb_sel;
  logic        lcd_sel;
  logic        cr_sel;
  logic        cr_rd;

  assign strb  = ~n_oe | ~n_we;
  // A new access begins on a strobe rising or on an address change mid-strobe.
  assign start = strb & (~strb_q | (a != a_q));

  // Region decode
  assign in_low  = ~a[15];
  assign in_mid  = (a[15:13] == 3'b100);
  assign in_io   = (a[15:8] == 8'hFF);
  assign in_win  = a[15] & ~in_mid & ~in_io;
  // 0xA..0xF in a[15:12] maps to window 0..5 (0xF window stops at 0xFEFF).
  assign win_idx = a[14:12] - 3'd2;

  // Window k is enabled by cr[3+k]; windows beyond N_WIN never respond.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_win
      if (gi < N_WIN) begin : g_on
        assign win_en[gi] = cr[3+gi];
      end else begin : g_off
        assign win_en[gi] = 1'b0;
      end
    end
  endgenerate

  assign win_hit  = in_win & win_en[win_idx];
  assign unmapped = in_win & ~win_en[win_idx];

  // I/O page, selected by a[2:1]; select 3 is reserved and does nothing.
  assign kb_sel  = in_io & (a[2:1] == 2'd0);
  assign lcd_sel = in_io & (a[2:1] == 2'd1);
  assign cr_sel  = in_io & (a[2:1] == 2'd2);

  assign dev_ws = kb_sel ? KB_W : (lcd_sel ? LCD_W : 4'd0);

  // The start cycle itself counts as the first wait cycle, hence W-1 below.
  assign busy  = n_rst & (start ? (dev_ws != 4'd0) : (cnt != 4'd0));
  assign n_rdy = unmapped | busy;

  assign n_rom_cs  = in_low ? cr[0] : 1'b1;
  assign n_raml_cs = in_low ? ~cr[0] : 1'b1;
  assign n_ramh_cs = ~(in_mid | win_hit);

  // Simultaneous n_oe/n_we: reads win for n_kb_oe/d_oe, writes win for kb_cp/CR.
  assign n_kb_oe = kb_sel ? n_oe : 1'b1;
  assign kb_cp   = kb_sel ? n_we : 1'b1;
  assign lcd_e   = lcd_sel & strb;

  assign cr_rd = cr_sel & ~n_oe;
  assign d_oe  = cr_rd;
  assign d_out = cr_rd ? cr : 8'h00;

  // wr_done limits a held write strobe to a single CR commit.
  assign commit = cr_sel & ~n_we & ~n_rdy & ~wr_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strb_q  <= 1'b0;
      a_q     <= 16'h0000;
      cnt     <= 4'd0;
      wr_done <= 1'b0;
      cr      <= CR_RESET;
    end else begin
      strb_q <= strb;
      a_q    <= a;
      // A new access restarts the count for the newly addressed device.
      if (start) begin
        cnt <= (dev_ws != 4'd0) ? (dev_ws - 4'd1) : 4'd0;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        cr <= d_in;
      end
      if (!strb) begin
        wr_done <= 1'b0;
      end else if (commit) begin
        wr_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_ws.sv
// Self-checking bench for io_ws. Stimulus pushes the expected outputs of each
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_io_ws;

  localparam int unsigned N_WIN    = 2;
  localparam int unsigned KB_WS    = 0;
  localparam int unsigned LCD_WS   = 3;
  localparam logic [7:0]  CR_RESET = 8'h00;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] a;
  logic        n_oe;
  logic        n_we;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  cr;
  logic        n_rdy;
  logic        n_rom_cs;
  logic        n_raml_cs;
  logic        n_ramh_cs;
  logic        n_kb_oe;
  logic        kb_cp;
  logic        lcd_e;

  always #5 clk = ~clk;

  io_ws #(
    .N_WIN(N_WIN), .KB_WS(KB_WS), .LCD_WS(LCD_WS), .CR_RESET(CR_RESET)
  ) dut (
    .clk(clk), .n_rst(n_rst), .a(a), .n_oe(n_oe), .n_we(n_we), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .cr(cr), .n_rdy(n_rdy),
    .n_rom_cs(n_rom_cs), .n_raml_cs(n_raml_cs), .n_ramh_cs(n_ramh_cs),
    .n_kb_oe(n_kb_oe), .kb_cp(kb_cp), .lcd_e(lcd_e)
  );

  typedef struct {
    logic       chk_bus;
    logic       n_rdy;
    logic       n_rom_cs;
    logic       n_raml_cs;
    logic       n_ramh_cs;
    logic       n_kb_oe;
    logic       kb_cp;
    logic       lcd_e;
    logic       d_oe;
    logic [7:0] d_out;
    logic [7:0] cr;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: CR contents, previous strobe/address, age of the
  // current access and the wait demanded by the device it started on.
  logic [7:0]  m_cr;
  logic        m_prev_strb;
  logic [15:0] m_prev_a;
  int          m_age;
  int          m_ws;
  bit          m_done;

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t a=%h actual=%b expected=%b", name, $time, a, act, expv);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t a=%h actual=%h expected=%h", name, $time, a, act, expv);
    end
  endtask

  function automatic int dev_wait(input logic [15:0] addr);
    if (addr >= 16'hFF00) begin
      if (addr[2:1] == 2'd0) return int'(KB_WS);
      if (addr[2:1] == 2'd1) return int'(LCD_WS);
    end
    return 0;
  endfunction

  // One bus cycle: drive inputs just after the rising edge, record what the
  // outputs must be during this cycle, then advance the model across the
  // next rising edge.
  task automatic step(input logic [15:0] addr, input logic oe, input logic we,
                      input logic [7:0] d, input logic rst);
    exp_t e;
    logic strb, start, busy, unmapped, cr_sel;
    int   k;
    @(posedge clk);
    #1;
    a = addr; n_oe = oe; n_we = we; d_in = d; n_rst = rst;
    if (!rst) begin
      m_cr = CR_RESET; m_prev_strb = 1'b0; m_prev_a = 16'h0000;
      m_age = 1000; m_ws = 0; m_done = 1'b0;
    end
    strb  = !oe || !we;
    start = rst && strb && (!m_prev_strb || addr != m_prev_a);
    if (start) begin
      m_ws  = dev_wait(addr);
      m_age = 0;
    end
    busy = rst && (m_age < m_ws);

    e.n_rom_cs = 1'b1; e.n_raml_cs = 1'b1; e.n_ramh_cs = 1'b1;
    e.n_kb_oe = 1'b1; e.kb_cp = 1'b1; e.lcd_e = 1'b0;
    e.d_oe = 1'b0; e.d_out = 8'h00; e.cr = m_cr;
    unmapped = 1'b0; cr_sel = 1'b0;
    if (addr < 16'h8000) begin
      e.n_rom_cs  = m_cr[0];
      e.n_raml_cs = !m_cr[0];
    end else if (addr < 16'hA000) begin
      e.n_ramh_cs = 1'b0;
    end else if (addr < 16'hFF00) begin
      k = (int'(addr) - 32'hA000) / 4096;
      if (k < int'(N_WIN) && m_cr[3+k]) e.n_ramh_cs = 1'b0;
      else unmapped = 1'b1;
    end else begin
      case (addr[2:1])
        2'd0: begin e.n_kb_oe = oe; e.kb_cp = we; end
        2'd1: e.lcd_e = strb;
        2'd2: cr_sel = 1'b1;
        default: ;
      endcase
    end
    e.n_rdy = unmapped || busy;
    if (cr_sel && !oe) begin
      e.d_oe  = 1'b1;
      e.d_out = m_cr;
    end
    e.chk_bus = strb;
    exp_q.push_back(e);

    if (rst) begin
      if (cr_sel && !we && !e.n_rdy && !m_done) begin
        m_cr   = d;
        m_done = 1'b1;
      end
      if (!strb) m_done = 1'b0;
      m_prev_strb = strb;
      m_prev_a    = addr;
      if (m_age < 1000) m_age++;
    end
  endtask

  // An access of len cycles followed by idle cycles; d_in is re-randomised
  // after the first cycle so a second CR commit would be visible.
  task automatic access(input logic [15:0] addr, input logic oe, input logic we,
                        input logic [7:0] d, input int len, input int idle);
    $display("access a=%h n_oe=%b n_we=%b d=%h len=%0d", addr, oe, we, d, len);
    for (int i = 0; i < len; i++) begin
      step(addr, oe, we, (i == 0) ? d : 8'($urandom), 1'b1);
    end
    for (int i = 0; i < idle; i++) begin
      step(addr, 1'b1, 1'b1, 8'($urandom), 1'b1);
    end
  endtask

  // Monitor: compare the current cycle's outputs against the queued record.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk8("cr", cr, e.cr);
      chk8("d_out", d_out, e.d_out);
      chk1("d_oe", d_oe, e.d_oe);
      chk1("n_kb_oe", n_kb_oe, e.n_kb_oe);
      chk1("kb_cp", kb_cp, e.kb_cp);
      chk1("lcd_e", lcd_e, e.lcd_e);
      if (e.chk_bus) begin
        chk1("n_rdy", n_rdy, e.n_rdy);
        chk1("n_rom_cs", n_rom_cs, e.n_rom_cs);
        chk1("n_raml_cs", n_raml_cs, e.n_raml_cs);
        chk1("n_ramh_cs", n_ramh_cs, e.n_ramh_cs);
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic        roe, rwe;
    int          cat, mode;

    n_rst = 1'b0; a = 16'h0000; n_oe = 1'b0; n_we = 1'b1; d_in = 8'h00;
    m_cr = CR_RESET; m_prev_strb = 1'b0; m_prev_a = 16'h0000;
    m_age = 1000; m_ws = 0; m_done = 1'b0;

    // Reset state, decode live during reset
    $display("reset");
    step(16'h0000, 1'b0, 1'b1, 8'h00, 1'b0);
    step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b0);
    step(16'h0000, 1'b1, 1'b1, 8'h00, 1'b0);
    step(16'h0000, 1'b1, 1'b1, 8'h00, 1'b1);

    // Address sweep with a read strobe held
    $display("sweep 0x0000-0xFFFF step 0x100 read");
    for (int i = 0; i < 256; i++) begin
      step(16'(i * 256), 1'b0, 1'b1, 8'h00, 1'b1);
    end
    step(16'hFFFE, 1'b0, 1'b1, 8'h00, 1'b1);
    access(16'hFFFE, 1'b1, 1'b1, 8'h00, 0, 3);

    // CR write held 3 cycles, then decode using the new CR
    access(16'hFF04, 1'b1, 1'b0, 8'h09, 3, 1);
    access(16'h0100, 1'b0, 1'b1, 8'h00, 2, 1);
    access(16'hA123, 1'b0, 1'b1, 8'h00, 2, 1);
    access(16'hB000, 1'b0, 1'b1, 8'h00, 1, 1);
    access(16'hFF05, 1'b0, 1'b1, 8'h00, 2, 1);

    // LCD wait states and restart on address change within the page
    access(16'hFF02, 1'b1, 1'b0, 8'h55, 5, 3);
    access(16'hFF02, 1'b0, 1'b1, 8'h00, 2, 0);
    access(16'hFF03, 1'b0, 1'b1, 8'h00, 5, 3);
    access(16'hFF02, 1'b1, 1'b0, 8'h00, 1, 3);

    // Keyboard: write then read, zero wait
    access(16'hFF00, 1'b1, 1'b0, 8'h00, 2, 1);
    access(16'hFF00, 1'b0, 1'b1, 8'h00, 2, 1);

    // All windows enabled, only N_WIN of them respond; simultaneous strobes on CR
    access(16'hFF04, 1'b0, 1'b0, 8'hFF, 2, 1);
    access(16'hC000, 1'b0, 1'b1, 8'h00, 2, 1);
    access(16'hB7FF, 1'b0, 1'b1, 8'h00, 1, 1);
    access(16'h1234, 1'b1, 1'b0, 8'h00, 1, 1);

    // Reset in the middle of an LCD wait, released with the strobe held
    $display("reset during LCD wait");
    step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b1);
    step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b1);
    step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b0);
    step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(16'hFF02, 1'b1, 1'b0, 8'h00, 1'b1);
    access(16'hFF02, 1'b1, 1'b1, 8'h00, 0, 3);

    // Randomised accesses; idle gaps let any wait count drain
    for (int n = 0; n < 150; n++) begin
      cat = int'($urandom_range(0, 7));
      case (cat)
        0: ra = 16'($urandom_range(0, 32'h7FFF));
        1: ra = 16'($urandom_range(32'h8000, 32'h9FFF));
        2: ra = 16'($urandom_range(32'hA000, 32'hFEFF));
        3, 4: ra = 16'hFF00 | 16'($urandom_range(0, 255));
        5: ra = 16'hFF04 | 16'($urandom_range(0, 1)) | (16'($urandom_range(0, 31)) << 3);
        6: ra = 16'hFF02 | 16'($urandom_range(0, 1));
        default: ra = 16'hFF00 | 16'($urandom_range(0, 1));
      endcase
      mode = int'($urandom_range(0, 2));
      roe = (mode == 1);
      rwe = (mode == 0);
      access(ra, roe, rwe, 8'($urandom), int'($urandom_range(1, 5)), 3);
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
